// File: rtl/lock_detect_v3_if.sv
// Signal bundle between the PLL controller and the windowed lock detector.
// Loss-of-lock handshake present only when LOCK_DETECT_LOSS_FLAG_EN is defined.
interface lock_detect_v3_if #(
  parameter int CNT_BITS  = 8,
  parameter int CONF_BITS = 3
);
  logic        [CNT_BITS-1:0]  lock_threshold;
  logic        [CNT_BITS-1:0]  unlock_threshold;
  logic        [CONF_BITS-1:0] confirm_windows;
  logic                        freq_up;
  logic                        freq_dn;
  logic                        ld_divide_enable;
  logic                        locked;
  logic        [1:0]           lock_state;
  logic signed [CNT_BITS-1:0]  last_error;
  logic                        window_done;
`ifdef LOCK_DETECT_LOSS_FLAG_EN
  logic                        clear_loss;
  logic                        loss_of_lock;
`endif

  modport master (
`ifdef LOCK_DETECT_LOSS_FLAG_EN
    output clear_loss,
    input  loss_of_lock,
`endif
    output lock_threshold, unlock_threshold, confirm_windows,
    output freq_up, freq_dn, ld_divide_enable,
    input  locked, lock_state, last_error, window_done
  );

  modport slave (
`ifdef LOCK_DETECT_LOSS_FLAG_EN
    input  clear_loss,
    output loss_of_lock,
`endif
    input  lock_threshold, unlock_threshold, confirm_windows,
    input  freq_up, freq_dn, ld_divide_enable,
    output locked, lock_state, last_error, window_done
  );
endinterface

// File: rtl/lock_detect_v3.sv
// Windowed frequency-lock detector: saturating up/down error integrator, 3-state lock FSM with hysteresis.
// Optional sticky loss-of-lock flag enabled by defining LOCK_DETECT_LOSS_FLAG_EN.
module lock_detect_v3 #(
  parameter int CNT_BITS  = 8,
  parameter int WIN_BITS  = 6,
  parameter int CONF_BITS = 3
) (
  input logic              clock,
  input logic              reset,
  lock_detect_v3_if.slave  bus
);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2
  } lock_state_e;

  localparam logic signed [CNT_BITS-1:0] ACC_MAX = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic signed [CNT_BITS-1:0] ACC_MIN = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic signed [CNT_BITS-1:0] ACC_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic        [CNT_BITS:0]   MAG_SAT = {1'b0, {CNT_BITS{1'b1}}};
  localparam logic        [CNT_BITS:0]   MAG_ONE = {{CNT_BITS{1'b0}}, 1'b1};
  localparam logic        [WIN_BITS-1:0] WIN_ONE = {{(WIN_BITS-1){1'b0}}, 1'b1};
  localparam logic        [CONF_BITS-1:0] CONF_ONE = {{(CONF_BITS-1){1'b0}}, 1'b1};

  lock_state_e                 state_q, state_nxt;
  logic signed [CNT_BITS-1:0]  acc_q, acc_nxt;
  logic                        sat_q;
  logic        [WIN_BITS-1:0]  win_q;
  logic        [CONF_BITS-1:0] good_q, good_nxt;
  logic signed [CNT_BITS-1:0]  last_error_q;
  logic                        window_done_q;

  logic                        enable;
  logic                        sat_evt;
  logic                        sat_win;
  logic                        terminal;
  logic        [CNT_BITS:0]    err_ext;
  logic        [CNT_BITS:0]    err_mag;
  logic                        win_good;
  logic                        win_bad;
  logic        [CONF_BITS-1:0] conf_eff;
  logic        [CONF_BITS-1:0] good_inc;

  assign enable   = bus.ld_divide_enable;
  assign terminal = enable && (win_q == {WIN_BITS{1'b1}});

  // Saturating integrator step; this cycle's event is already folded into acc_nxt.
  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    acc_nxt = acc_q;
    sat_evt = 1'b0;
    if (bus.freq_up && !bus.freq_dn) begin
      if (acc_q == ACC_MAX) sat_evt = 1'b1;
      else                  acc_nxt = acc_q + ACC_ONE;
    end else if (bus.freq_dn && !bus.freq_up) begin
      if (acc_q == ACC_MIN) sat_evt = 1'b1;
      else                  acc_nxt = acc_q - ACC_ONE;
    end
  end

  assign sat_win = sat_q | sat_evt;

  // Magnitude needs one extra bit so the most negative value does not wrap.
  always_comb begin
    err_ext = {acc_nxt[CNT_BITS-1], acc_nxt};
    if (sat_win)                err_mag = MAG_SAT;
    else if (err_ext[CNT_BITS]) err_mag = ~err_ext + MAG_ONE;
    else                        err_mag = err_ext;
  end

  assign win_good = err_mag <= {1'b0, bus.lock_threshold};
  assign win_bad  = err_mag >  {1'b0, bus.unlock_threshold};
  assign conf_eff = (bus.confirm_windows == '0) ? CONF_ONE : bus.confirm_windows;
  assign good_inc = good_q + CONF_ONE;

  // Window counter, integrator and evaluation registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q         <= '0;
      sat_q         <= 1'b0;
      win_q         <= '0;
      last_error_q  <= '0;
      window_done_q <= 1'b0;
    end else if (!enable) begin
      acc_q         <= '0;
      sat_q         <= 1'b0;
      win_q         <= '0;
      window_done_q <= 1'b0;
    end else begin
      win_q         <= win_q + WIN_ONE;
      window_done_q <= terminal;
      if (terminal) begin
        acc_q        <= '0;
        sat_q        <= 1'b0;
        last_error_q <= acc_nxt;
      end else begin
        acc_q <= acc_nxt;
        sat_q <= sat_win;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_nxt;
      good_q  <= good_nxt;
    end
  end

  // FSM: next state. Saturation while locked drops lock immediately, ahead of window evaluation.
  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    if (!enable) begin
      state_nxt = UNLOCKED;
      good_nxt  = '0;
    end else if (state_q == LOCKED && sat_evt) begin
      state_nxt = UNLOCKED;
      good_nxt  = '0;
    end else if (terminal) begin
      case (state_q)
        UNLOCKED: begin
          if (win_good) begin
            good_nxt  = CONF_ONE;
            state_nxt = (conf_eff == CONF_ONE) ? LOCKED : ACQUIRING;
          end
        end
        ACQUIRING: begin
          if (win_good) begin
            good_nxt = good_inc;
            if (good_inc >= conf_eff) state_nxt = LOCKED;
          end else begin
            state_nxt = UNLOCKED;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          if (win_bad) begin
            state_nxt = UNLOCKED;
            good_nxt  = '0;
          end
        end
        default: begin
          state_nxt = UNLOCKED;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // FSM: outputs, all decoded from flops.
  always_comb begin
    bus.locked      = (state_q == LOCKED);
    bus.lock_state  = state_q;
    bus.last_error  = last_error_q;
    bus.window_done = window_done_q;
  end

`ifdef LOCK_DETECT_LOSS_FLAG_EN
  logic loss_q;

  // Sticky loss flag; a new loss in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        loss_q <= 1'b0;
    else if (state_q == LOCKED && state_nxt != LOCKED) loss_q <= 1'b1;
    else if (bus.clear_loss)                           loss_q <= 1'b0;
  end

  assign bus.loss_of_lock = loss_q;
`endif

endmodule
